// File: rtl/interleaver_bank_sched_if.sv
// Bus bundle for the two-bank interleaver scheduler: block input handshake,
// bank write controls, and drain-side read controls.
interface interleaver_bank_sched_if;
  // Input side: block framing from the upstream CRC stage
  logic        CRC_start;
  logic        CRC_blocksize;
  logic        CRC_end;
  logic        in_ready;
  // Write side: address and per-bank write enables
  logic [12:0] wr_addr;
  logic        ram1_we;
  logic        ram2_we;
  // Read side: natural-order index, bank select and output qualifiers
  logic [12:0] rd_addr;
  logic        rd_bank;
  logic        rd_blocksize;
  logic        data_ready;
  logic        done;
  logic        err;

  // Block source / consumer of the scheduler controls
  modport master (
    output CRC_start, CRC_blocksize, CRC_end,
    input  in_ready, wr_addr, ram1_we, ram2_we,
    input  rd_addr, rd_bank, rd_blocksize, data_ready, done, err
  );

  // Scheduler itself
  modport slave (
    input  CRC_start, CRC_blocksize, CRC_end,
    output in_ready, wr_addr, ram1_we, ram2_we,
    output rd_addr, rd_bank, rd_blocksize, data_ready, done, err
  );
endinterface

// File: rtl/interleaver_bank_sched.sv
// Ping-pong bank scheduler for a block interleaver. Blocks are written into
// alternating RAM banks in natural order while the previously filled bank is
// drained; the read index goes to an external permutation table. A small
// pipeline tags every issued read with its bank/size so the output mux and
// data_ready/done stay aligned with the RAM read latency.
module interleaver_bank_sched #(
  parameter int SMALL_K = 1056,
  parameter int LARGE_K = 6144,
  parameter int RD_LAT  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  interleaver_bank_sched_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } bank_state_e;

  localparam logic [12:0] SMALL_LAST = 13'(SMALL_K - 1);
  localparam logic [12:0] LARGE_LAST = 13'(LARGE_K - 1);

  // Per-bank state and stored block size
  bank_state_e bank_q [2];
  bank_state_e bank_d [2];
  logic [1:0]  size_q, size_d;

  // Write pointer alternates on every successful fill; read pointer follows
  // the same order so the oldest FULL bank is always the one it points at.
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [12:0] wr_cnt_q, wr_cnt_d;
  logic [12:0] rd_cnt_q, rd_cnt_d;

  // Bank/size of the most recent drain, shown when no read is in flight
  logic        cur_bank_q, cur_bank_d;
  logic        cur_size_q, cur_size_d;
  logic        err_q, err_d;

  // Read-latency pipeline: valid, bank, size and last-bit tag per stage
  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [RD_LAT-1:0] pb_q, pb_d;
  logic [RD_LAT-1:0] ps_q, ps_d;
  logic [RD_LAT-1:0] pl_q, pl_d;

  logic        filling;
  logic        draining;
  logic        drain_bank;
  logic [12:0] drain_last;
  logic        drain_end;
  logic        drain_start;
  logic        in_ready;
  logic        start_ok;
  logic        start_bad;
  logic        writing;
  logic        w_size;
  logic [12:0] w_addr;
  logic [12:0] w_last;
  logic        at_last;
  logic        fill_ok;
  logic        fill_bad;
  logic        out_bank;
  logic        out_size;

  // Decode bank status and classify this cycle's write-side events
  always_comb begin
    filling     = (bank_q[0] == FILL)  || (bank_q[1] == FILL);
    draining    = (bank_q[0] == DRAIN) || (bank_q[1] == DRAIN);
    drain_bank  = (bank_q[1] == DRAIN);
    drain_last  = size_q[drain_bank] ? LARGE_LAST : SMALL_LAST;
    drain_end   = draining && (rd_cnt_q == drain_last);
    // A drain issuing its last index counts as finished so the next FULL
    // bank can follow without a bubble.
    drain_start = (bank_q[rd_ptr_q] == FULL) && (!draining || drain_end);
    // The pointed-at bank is free if it is EMPTY now or becomes EMPTY next.
    in_ready    = reset && ((bank_q[wr_ptr_q] == EMPTY) ||
                            ((bank_q[wr_ptr_q] == DRAIN) && drain_end));
    start_ok    = bus.CRC_start && in_ready;
    start_bad   = reset && bus.CRC_start && !in_ready;
    writing     = start_ok || filling;
    w_size      = start_ok ? bus.CRC_blocksize : size_q[wr_ptr_q];
    w_addr      = start_ok ? 13'd0 : wr_cnt_q;
    w_last      = w_size ? LARGE_LAST : SMALL_LAST;
    at_last     = (w_addr == w_last);
    fill_ok     = writing && bus.CRC_end && at_last;
    // CRC_end off the last address, or the last address without CRC_end
    fill_bad    = writing && (bus.CRC_end != at_last);
  end

  // Next-state for banks, pointers, counters and the read pipeline
  always_comb begin
    bank_d     = bank_q;
    size_d     = size_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    cur_bank_d = cur_bank_q;
    cur_size_d = cur_size_q;

    if (draining) begin
      if (drain_end) begin
        bank_d[drain_bank] = EMPTY;
        rd_cnt_d           = 13'd0;
      end else begin
        rd_cnt_d = rd_cnt_q + 13'd1;
      end
    end

    if (drain_start) begin
      bank_d[rd_ptr_q] = DRAIN;
      rd_cnt_d         = 13'd0;
      rd_ptr_d         = !rd_ptr_q;
      cur_bank_d       = rd_ptr_q;
      cur_size_d       = size_q[rd_ptr_q];
    end

    // Fill updates come last so a start into a just-drained bank wins
    if (start_ok) begin
      bank_d[wr_ptr_q] = FILL;
      size_d[wr_ptr_q] = bus.CRC_blocksize;
      wr_cnt_d         = 13'd1;
    end else if (filling) begin
      wr_cnt_d = wr_cnt_q + 13'd1;
    end

    if (fill_ok) begin
      bank_d[wr_ptr_q] = FULL;
      wr_ptr_d         = !wr_ptr_q;
      wr_cnt_d         = 13'd0;
    end else if (fill_bad) begin
      bank_d[wr_ptr_q] = EMPTY;
      wr_cnt_d         = 13'd0;
    end

    err_d = start_bad || fill_bad;

    // Stage 0 captures the read issued this cycle; higher stages are older
    pv_d = (pv_q << 1) | RD_LAT'(draining);
    pb_d = (pb_q << 1) | RD_LAT'(drain_bank);
    ps_d = (ps_q << 1) | RD_LAT'(size_q[drain_bank]);
    pl_d = (pl_q << 1) | RD_LAT'(drain_end);
  end

  // Output bank/size follow the oldest read still in flight
  always_comb begin
    out_bank = cur_bank_q;
    out_size = cur_size_q;
    for (int i = 0; i < RD_LAT; i++) begin
      if (pv_q[i]) begin
        out_bank = pb_q[i];
        out_size = ps_q[i];
      end
    end
  end

  // State registers; reset aborts any fill or drain in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_q[0]  <= EMPTY;
      bank_q[1]  <= EMPTY;
      size_q     <= 2'b00;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_cnt_q   <= 13'd0;
      rd_cnt_q   <= 13'd0;
      cur_bank_q <= 1'b0;
      cur_size_q <= 1'b0;
      err_q      <= 1'b0;
      pv_q       <= '0;
      pb_q       <= '0;
      ps_q       <= '0;
      pl_q       <= '0;
    end else begin
      bank_q     <= bank_d;
      size_q     <= size_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      cur_bank_q <= cur_bank_d;
      cur_size_q <= cur_size_d;
      err_q      <= err_d;
      pv_q       <= pv_d;
      pb_q       <= pb_d;
      ps_q       <= ps_d;
      pl_q       <= pl_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.wr_addr      = w_addr;
  assign bus.ram1_we      = writing && !wr_ptr_q;
  assign bus.ram2_we      = writing && wr_ptr_q;
  assign bus.rd_addr      = rd_cnt_q;
  assign bus.rd_bank      = out_bank;
  assign bus.rd_blocksize = out_size;
  assign bus.data_ready   = pv_q[RD_LAT-1];
  assign bus.done         = pv_q[RD_LAT-1] && pl_q[RD_LAT-1];
  assign bus.err          = err_q;

endmodule

// File: tb/tb_interleaver_bank_sched.sv
// Bench for interleaver_bank_sched. A timing model predicts, from block
// completion times alone, when each block drains, when each bank frees up
// and when err must pulse; a negedge monitor checks the read side against it.
module tb_interleaver_bank_sched;
  localparam int SK  = 1056;
  localparam int LK  = 6144;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset;
  interleaver_bank_sched_if bus();

  interleaver_bank_sched #(
    .SMALL_K(SK),
    .LARGE_K(LK),
    .RD_LAT (LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit bank;
    bit size;
    int s;      // cycle the first read index of the block is issued
  } blk_t;

  blk_t        exp_q[$];
  int          m_free[2];     // first cycle each bank can accept a start
  bit          m_wr_ptr;
  int          m_last_issue;  // cycle of the last read index of the newest drain
  bit          err_set[int];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          mon_en   = 1'b0;
  logic [12:0] rd_hist [8];

  always @(posedge clk) cyc <= cyc + 1;

  // Read-side monitor
  always @(negedge clk) begin
    int k, idx;
    bit exp_dr, exp_err;
    rd_hist[cyc & 7] = bus.rd_addr;
    if (mon_en) begin
      exp_err = err_set.exists(cyc);
      if (exp_err) err_set.delete(cyc);
      n_checks++;
      if (bus.err !== exp_err) begin
        n_fail++;
        $display("FAIL err cyc=%0d got=%b want=%b", cyc, bus.err, exp_err);
      end
      exp_dr = 1'b0; idx = 0; k = SK;
      if (exp_q.size() > 0) begin
        k      = exp_q[0].size ? LK : SK;
        idx    = cyc - exp_q[0].s - LAT;
        exp_dr = (idx >= 0) && (idx < k);
      end
      n_checks++;
      if (bus.data_ready !== exp_dr) begin
        n_fail++;
        $display("FAIL data_ready cyc=%0d got=%b want=%b", cyc, bus.data_ready, exp_dr);
      end
      if (exp_dr) begin
        n_checks++;
        if (bus.rd_bank !== exp_q[0].bank || bus.rd_blocksize !== exp_q[0].size) begin
          n_fail++;
          $display("FAIL rd_bank/size cyc=%0d idx=%0d got=%b/%b want=%b/%b", cyc, idx,
                   bus.rd_bank, bus.rd_blocksize, exp_q[0].bank, exp_q[0].size);
        end
        n_checks++;
        if (bus.done !== (idx == k - 1)) begin
          n_fail++;
          $display("FAIL done cyc=%0d idx=%0d got=%b want=%b", cyc, idx, bus.done, (idx == k - 1));
        end
        n_checks++;
        if (rd_hist[(cyc - LAT) & 7] !== 13'(idx)) begin
          n_fail++;
          $display("FAIL rd_addr_lat cyc=%0d got=%0d want=%0d", cyc, rd_hist[(cyc - LAT) & 7], idx);
        end
        if (idx == k - 1) void'(exp_q.pop_front());
      end else begin
        n_checks++;
        if (bus.done !== 1'b0) begin
          n_fail++;
          $display("FAIL done_idle cyc=%0d got=%b want=0", cyc, bus.done);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    m_wr_ptr     = 1'b0;
    m_free[0]    = 0;
    m_free[1]    = 0;
    m_last_issue = -100000;
    exp_q.delete();
    err_set.delete();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      step();
      bus.CRC_start = 1'b0;
      bus.CRC_end   = 1'b0;
      #1;
      n_checks++;
      if (bus.in_ready !== (cyc >= m_free[m_wr_ptr])) begin
        n_fail++;
        $display("FAIL in_ready_idle cyc=%0d got=%b want=%b", cyc, bus.in_ready, (cyc >= m_free[m_wr_ptr]));
      end
      n_checks++;
      if ({bus.ram1_we, bus.ram2_we} !== 2'b00) begin
        n_fail++;
        $display("FAIL we_idle cyc=%0d got=%b%b want=00", cyc, bus.ram1_we, bus.ram2_we);
      end
    end
  endtask

  // end_at: K-1 normal, < K-1 early CRC_end, >= K no CRC_end at all
  task automatic send_block(input bit sz, input int end_at, input bit rogue, input int abort_at);
    int k, b, e, s;
    bit acc;
    blk_t nb;
    k = sz ? LK : SK;
    b = m_wr_ptr;
    step();
    acc = (cyc >= m_free[b]);
    n_checks++;
    if (bus.in_ready !== acc) begin
      n_fail++;
      $display("FAIL in_ready_start cyc=%0d got=%b want=%b", cyc, bus.in_ready, acc);
    end
    bus.CRC_start     = 1'b1;
    bus.CRC_blocksize = sz;
    bus.CRC_end       = (end_at == 0);
    if (!acc) begin
      err_set[cyc + 1] = 1'b1;
      #1;
      n_checks++;
      if ({bus.ram1_we, bus.ram2_we} !== 2'b00) begin
        n_fail++;
        $display("FAIL we_rejected cyc=%0d got=%b%b want=00", cyc, bus.ram1_we, bus.ram2_we);
      end
      return;
    end
    m_free[b] = 32'h7fffffff;
    for (int i = 0; i < k; i++) begin
      if (i > 0) begin
        step();
        bus.CRC_start = rogue && ($urandom_range(0, 149) == 0);
        bus.CRC_end   = (i == end_at);
        if (bus.CRC_start) err_set[cyc + 1] = 1'b1;
      end
      #1;
      n_checks++;
      if (bus.ram1_we !== (b == 0) || bus.ram2_we !== (b == 1) || bus.wr_addr !== 13'(i)) begin
        n_fail++;
        $display("FAIL fill cyc=%0d got we=%b%b addr=%0d want we=%b%b addr=%0d", cyc,
                 bus.ram1_we, bus.ram2_we, bus.wr_addr, (b == 0), (b == 1), i);
      end
      if (i == abort_at) return;
      if (i == end_at || i == k - 1) break;
    end
    e = cyc;
    if (end_at == k - 1) begin
      s            = (e + 2 > m_last_issue + 1) ? e + 2 : m_last_issue + 1;
      m_last_issue = s + k - 1;
      m_free[b]    = s + k - 1;
      nb.bank      = b[0];
      nb.size      = sz;
      nb.s         = s;
      exp_q.push_back(nb);
      m_wr_ptr     = !m_wr_ptr;
    end else begin
      err_set[e + 1] = 1'b1;
      m_free[b]      = e + 1;
    end
  endtask

  task automatic wait_drained();
    int guard = 0;
    while ((exp_q.size() > 0 || cyc < m_last_issue + LAT + 2) && guard < 20000) begin
      idle(1);
      guard++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout cyc=%0d got=%0d blocks pending want=0", cyc, exp_q.size());
    end
  endtask

  task automatic do_reset();
    bus.CRC_start = 1'b0;
    bus.CRC_end   = 1'b0;
    reset  = 1'b0;
    mon_en = 1'b0;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.wr_addr, bus.ram1_we, bus.ram2_we, bus.rd_addr, bus.rd_bank,
         bus.rd_blocksize, bus.data_ready, bus.done, bus.err} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_values got rdy=%b wa=%0d we=%b%b ra=%0d bk=%b sz=%b dr=%b dn=%b er=%b want all 0",
               bus.in_ready, bus.wr_addr, bus.ram1_we, bus.ram2_we, bus.rd_addr, bus.rd_bank,
               bus.rd_blocksize, bus.data_ready, bus.done, bus.err);
    end
    repeat (3) @(posedge clk);
    clear_model();
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.data_ready !== 1'b0 || bus.err !== 1'b0 || bus.rd_addr !== 13'd0) begin
      n_fail++;
      $display("FAIL release got rdy=%b dr=%b er=%b ra=%0d want 1/0/0/0",
               bus.in_ready, bus.data_ready, bus.err, bus.rd_addr);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    idle(5);
  endtask

  task automatic test_single_small();
    send_block(1'b0, SK - 1, 1'b0, -1);
    wait_drained();
  endtask

  task automatic test_back_to_back();
    send_block(1'b1, LK - 1, 1'b0, -1);
    send_block(1'b0, SK - 1, 1'b0, -1);
    wait_drained();
  endtask

  task automatic test_three_blocks();
    send_block(1'b1, LK - 1, 1'b0, -1);
    send_block(1'b0, SK - 1, 1'b0, -1);
    send_block(1'b0, SK - 1, 1'b0, -1);   // both banks occupied: rejected
    wait_drained();
  endtask

  task automatic test_early_end();
    do_reset();
    send_block(1'b0, 500, 1'b0, -1);
    send_block(1'b0, SK - 1, 1'b0, -1);
    wait_drained();
    send_block(1'b0, SK, 1'b0, -1);       // no CRC_end at all
    idle(3);
  endtask

  task automatic test_reset_abort();
    send_block(1'b0, SK - 1, 1'b0, -1);
    idle(300);                            // mid-drain
    do_reset();
    send_block(1'b1, LK - 1, 1'b0, 3000); // mid-fill at wr_addr 3000
    do_reset();
    send_block(1'b0, SK - 1, 1'b0, -1);
    wait_drained();
  endtask

  task automatic test_random();
    int k, r, end_at;
    bit sz;
    for (int n = 0; n < 8; n++) begin
      sz = (n == 3);
      k  = sz ? LK : SK;
      r  = $urandom_range(0, 5);
      end_at = (r == 0) ? $urandom_range(0, k - 2) : ((r == 1) ? k : k - 1);
      idle($urandom_range(0, 3));
      send_block(sz, end_at, 1'b1, -1);
    end
    wait_drained();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.CRC_start     = 1'b0;
    bus.CRC_blocksize = 1'b0;
    bus.CRC_end       = 1'b0;
    clear_model();
    test_reset();
    test_single_small();
    test_back_to_back();
    test_three_blocks();
    test_early_end();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interleaver_bank_sched.md
INTERLEAVER_BANK_SCHED -- requirements
Module: interleaver_bank_sched

Parameters
REQ-001 SHALL provide SMALL_K, default 1056, bits per block when CRC_blocksize=0 (1..8191).
REQ-002 SHALL provide LARGE_K, default 6144, bits per block when CRC_blocksize=1 (1..8191).
REQ-003 SHALL provide RD_LAT, default 1, RAM read latency in cycles (1..3).

Interface
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low; asserted clears all state immediately.
REQ-006 CRC_start  in  1  first bit of a block present on data_in this cycle.
REQ-007 CRC_blocksize  in  1  block size, sampled only with CRC_start (0 small, 1 large).
REQ-008 CRC_end  in  1  last bit of the block present this cycle.
REQ-009 in_ready  out  1  a bank is free; CRC_start is accepted.
REQ-010 wr_addr  out  13  write address for the bank being filled.
REQ-011 ram1_we / ram2_we  out  1 each  write enables for bank 1 / bank 2.
REQ-012 rd_addr  out  13  natural-order read index (external permutation table maps it).
REQ-013 rd_bank  out  1  bank being drained (0 = bank 1, 1 = bank 2); selects output mux.
REQ-014 rd_blocksize  out  1  block size of the bank being drained.
REQ-015 data_ready  out  1  output bit valid this cycle.
REQ-016 done  out  1  one-cycle pulse with the last valid output bit of a block.
REQ-017 err  out  1  one-cycle pulse on a protocol violation.

Function
REQ-018 Each bank SHALL hold state EMPTY, FILL, FULL or DRAIN, plus a stored size bit.
REQ-019 Write pointer SHALL alternate banks, starting at bank 1 after reset; in_ready=1 iff the bank at the write pointer is EMPTY.
REQ-020 CRC_start with in_ready=1 and no block filling: that bank -> FILL, wr_addr=0, its we=1 that cycle; size latched.
REQ-021 While FILL, each cycle: we=1, wr_addr increments by 1; the other bank's we=0 always.
REQ-022 CRC_end at wr_addr=K-1: bank -> FULL next cycle, write pointer toggles.
REQ-023 CRC_end at wr_addr != K-1, or wr_addr reaching K-1 without CRC_end: err pulse, bank -> EMPTY, pointer unchanged, block discarded.
REQ-024 CRC_start while filling or with in_ready=0: ignored, err pulse; current fill unaffected.
REQ-025 With no bank in DRAIN, the oldest FULL bank SHALL enter DRAIN next cycle; rd_addr=0, rd_bank/rd_blocksize set.
REQ-026 While DRAIN, rd_addr increments each cycle through K-1; data_ready=1 exactly RD_LAT cycles after each rd_addr issue.
REQ-027 done SHALL assert with the data_ready of index K-1; the bank -> EMPTY the cycle after rd_addr=K-1 is issued.
REQ-028 rd_bank SHALL hold through the final data_ready of a block even if the next drain has begun (RD_LAT pipeline tracks bank per bit).
REQ-029 Fill of one bank and drain of the other SHALL proceed concurrently; no bubble when a fill completes the same cycle a drain ends.
REQ-030 A bank completing drain and accepting CRC_start in the same cycle: CRC_start accepted (in_ready computed from next-state EMPTY).
REQ-031 Addresses SHALL never exceed K-1; counters are 13-bit, no wrap.

Reset
REQ-032 On reset: both banks EMPTY, write pointer = bank 1, wr_addr=rd_addr=0, ram1_we=ram2_we=0, rd_bank=0, rd_blocksize=0, data_ready=0, done=0, err=0, in_ready=1 after release.
REQ-033 Reset mid-fill or mid-drain SHALL abort immediately; no data_ready/done for the partial block after release.

Verification
REQ-034 Single small block: CRC_start, 1056 bits, CRC_end at bit 1055 -> ram1_we for 1056 cycles; data_ready 1056 cycles, rd_bank=0, done with the last.
REQ-035 Back-to-back large then small: second block fills bank 2 while bank 1 drains; rd_bank 0 then 1; two done pulses, no gap.
REQ-036 Three blocks with reader stalled full: third CRC_start while both banks FULL/DRAIN -> in_ready=0, err pulse, block ignored.
REQ-037 Early CRC_end at bit 500 of small block -> err pulse, bank 1 EMPTY, no data_ready, next block goes to bank 1.
REQ-038 reset asserted at wr_addr=3000 of a large block -> all outputs at reset values asynchronously; fresh block after release drains correctly.
REQ-039 RD_LAT=3: data_ready/done trail rd_addr by 3 cycles; rd_bank correct across bank switch.
